// File: rtl/axi4_lite_arbiter_m2s1_if.sv
// AXI4-Lite channel bundle shared by the masters and the slave of the 2:1 arbiter.
// The master modport drives requests; the slave modport drives accepts and responses.
interface axi4_lite_arbiter_m2s1_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_arbiter_m2s1.sv
// Two-master, one-slave AXI4-Lite arbiter: independent round-robin write and read FSMs,
// each holding its grant from address handshake until the response handshake.
module axi4_lite_arbiter_m2s1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  axi4_lite_arbiter_m2s1_if.slave  m0,
  axi4_lite_arbiter_m2s1_if.slave  m1,
  axi4_lite_arbiter_m2s1_if.master s
);
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state_reg;
  logic     wgnt_reg;
  logic     wlast_reg;
  logic     aw_done_reg;
  logic     w_done_reg;
  r_state_t r_state_reg;
  logic     rgnt_reg;
  logic     rlast_reg;

  logic [ADDR_WIDTH-1:0]   awaddr_sel;
  logic [DATA_WIDTH-1:0]   wdata_sel;
  logic [DATA_WIDTH/8-1:0] wstrb_sel;
  logic [ADDR_WIDTH-1:0]   araddr_sel;
  logic awvalid_sel, wvalid_sel, bready_sel, arvalid_sel, rready_sel;
  logic aw_fwd, w_fwd, b_fwd, ar_fwd, r_fwd;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wpick, rpick;

  // Payloads follow the grant register in every state; only VALID/READY are gated.
  assign awaddr_sel  = wgnt_reg ? m1.awaddr  : m0.awaddr;
  assign wdata_sel   = wgnt_reg ? m1.wdata   : m0.wdata;
  assign wstrb_sel   = wgnt_reg ? m1.wstrb   : m0.wstrb;
  assign araddr_sel  = rgnt_reg ? m1.araddr  : m0.araddr;
  assign awvalid_sel = wgnt_reg ? m1.awvalid : m0.awvalid;
  assign wvalid_sel  = wgnt_reg ? m1.wvalid  : m0.wvalid;
  assign bready_sel  = wgnt_reg ? m1.bready  : m0.bready;
  assign arvalid_sel = rgnt_reg ? m1.arvalid : m0.arvalid;
  assign rready_sel  = rgnt_reg ? m1.rready  : m0.rready;

  assign aw_fwd = (w_state_reg == W_XFER) && !aw_done_reg;
  assign w_fwd  = (w_state_reg == W_XFER) && !w_done_reg;
  assign b_fwd  = (w_state_reg == W_RESP);
  assign ar_fwd = (r_state_reg == R_ADDR);
  assign r_fwd  = (r_state_reg == R_DATA);

  assign s.awaddr  = awaddr_sel;
  assign s.wdata   = wdata_sel;
  assign s.wstrb   = wstrb_sel;
  assign s.araddr  = araddr_sel;
  assign s.awvalid = aw_fwd && awvalid_sel;
  assign s.wvalid  = w_fwd && wvalid_sel;
  assign s.bready  = b_fwd && bready_sel;
  assign s.arvalid = ar_fwd && arvalid_sel;
  assign s.rready  = r_fwd && rready_sel;

  assign m0.awready = aw_fwd && s.awready && !wgnt_reg;
  assign m1.awready = aw_fwd && s.awready &&  wgnt_reg;
  assign m0.wready  = w_fwd  && s.wready  && !wgnt_reg;
  assign m1.wready  = w_fwd  && s.wready  &&  wgnt_reg;
  assign m0.bvalid  = b_fwd  && s.bvalid  && !wgnt_reg;
  assign m1.bvalid  = b_fwd  && s.bvalid  &&  wgnt_reg;
  assign m0.arready = ar_fwd && s.arready && !rgnt_reg;
  assign m1.arready = ar_fwd && s.arready &&  rgnt_reg;
  assign m0.rvalid  = r_fwd  && s.rvalid  && !rgnt_reg;
  assign m1.rvalid  = r_fwd  && s.rvalid  &&  rgnt_reg;
  assign m0.bresp   = s.bresp;
  assign m1.bresp   = s.bresp;
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m1.rresp   = s.rresp;

  assign aw_hs = s.awvalid && s.awready;
  assign w_hs  = s.wvalid  && s.wready;
  assign b_hs  = s.bvalid  && s.bready;
  assign ar_hs = s.arvalid && s.arready;
  assign r_hs  = s.rvalid  && s.rready;

  // On a tie the master that was not served last wins.
  assign wpick = m1.awvalid && (!m0.awvalid || !wlast_reg);
  assign rpick = m1.arvalid && (!m0.arvalid || !rlast_reg);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      w_state_reg <= W_IDLE;
      wgnt_reg    <= 1'b0;
      wlast_reg   <= 1'b1;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (m0.awvalid || m1.awvalid) begin
            wgnt_reg    <= wpick;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            w_state_reg <= W_XFER;
          end
        end
        W_XFER: begin
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs)  w_done_reg  <= 1'b1;
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) w_state_reg <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            wlast_reg   <= wgnt_reg;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state_reg <= R_IDLE;
      rgnt_reg    <= 1'b0;
      rlast_reg   <= 1'b1;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (m0.arvalid || m1.arvalid) begin
            rgnt_reg    <= rpick;
            r_state_reg <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) r_state_reg <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            rlast_reg   <= rgnt_reg;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_arbiter_m2s1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter: two master drivers, a reactive slave
// model, and scoreboard queues of expected write/read transactions in grant order.
module tb_axi4_lite_arbiter_m2s1;
    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    axi4_lite_arbiter_m2s1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
    axi4_lite_arbiter_m2s1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
    axi4_lite_arbiter_m2s1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    axi4_lite_arbiter_m2s1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .m0   (m0_if),
        .m1   (m1_if),
        .s    (s_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic report_fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    logic [1:0]       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [1:0][31:0] m_awaddr, m_wdata, m_araddr;
    logic [1:0][3:0]  m_wstrb;
    logic [1:0]       m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0][1:0]  m_bresp, m_rresp;
    logic [1:0][31:0] m_rdata;

    assign m0_if.awvalid = m_awvalid[0];  assign m1_if.awvalid = m_awvalid[1];
    assign m0_if.awaddr  = m_awaddr[0];   assign m1_if.awaddr  = m_awaddr[1];
    assign m0_if.wvalid  = m_wvalid[0];   assign m1_if.wvalid  = m_wvalid[1];
    assign m0_if.wdata   = m_wdata[0];    assign m1_if.wdata   = m_wdata[1];
    assign m0_if.wstrb   = m_wstrb[0];    assign m1_if.wstrb   = m_wstrb[1];
    assign m0_if.bready  = m_bready[0];   assign m1_if.bready  = m_bready[1];
    assign m0_if.arvalid = m_arvalid[0];  assign m1_if.arvalid = m_arvalid[1];
    assign m0_if.araddr  = m_araddr[0];   assign m1_if.araddr  = m_araddr[1];
    assign m0_if.rready  = m_rready[0];   assign m1_if.rready  = m_rready[1];
    assign m_awready = {m1_if.awready, m0_if.awready};
    assign m_wready  = {m1_if.wready,  m0_if.wready};
    assign m_bvalid  = {m1_if.bvalid,  m0_if.bvalid};
    assign m_arready = {m1_if.arready, m0_if.arready};
    assign m_rvalid  = {m1_if.rvalid,  m0_if.rvalid};
    assign m_bresp   = {m1_if.bresp,   m0_if.bresp};
    assign m_rresp   = {m1_if.rresp,   m0_if.rresp};
    assign m_rdata   = {m1_if.rdata,   m0_if.rdata};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } txn_t;

    txn_t wq[$];
    txn_t rq[$];
    bit   have_aw, have_w;

    initial begin : slave_model
        bit cap_aw, cap_w, cap_b, cap_ar, cap_r;
        s_if.bvalid = 1'b0; s_if.bresp = 2'b00;
        s_if.rvalid = 1'b0; s_if.rdata = 32'h0; s_if.rresp = 2'b00;
        have_aw = 1'b0; have_w = 1'b0;
        forever begin
            @(negedge iCLK);
            cap_aw = s_if.awvalid && s_if.awready;
            cap_w  = s_if.wvalid  && s_if.wready;
            cap_b  = s_if.bvalid  && s_if.bready;
            cap_ar = s_if.arvalid && s_if.arready;
            cap_r  = s_if.rvalid  && s_if.rready;
            if (cap_aw) begin
                n_cmp++;
                if ((wq.size() > 0) !== 1'b1) report_fail("wq_has_entry_at_aw", wq.size(), 1);
                if (wq.size() > 0) begin
                    n_cmp++;
                    if (s_if.awaddr !== wq[0].addr) report_fail("s_awaddr", s_if.awaddr, wq[0].addr);
                end
            end
            if (cap_w) begin
                n_cmp++;
                if ((wq.size() > 0) !== 1'b1) report_fail("wq_has_entry_at_w", wq.size(), 1);
                if (wq.size() > 0) begin
                    n_cmp++;
                    if (s_if.wdata !== wq[0].data) report_fail("s_wdata", s_if.wdata, wq[0].data);
                    n_cmp++;
                    if (s_if.wstrb !== wq[0].strb) report_fail("s_wstrb", s_if.wstrb, wq[0].strb);
                end
            end
            if (cap_ar) begin
                n_cmp++;
                if ((rq.size() > 0) !== 1'b1) report_fail("rq_has_entry_at_ar", rq.size(), 1);
                if (rq.size() > 0) begin
                    n_cmp++;
                    if (s_if.araddr !== rq[0].addr) report_fail("s_araddr", s_if.araddr, rq[0].addr);
                end
            end
            @(posedge iCLK);
            #1;
            if (iRST) begin
                have_aw = 1'b0; have_w = 1'b0;
                s_if.bvalid = 1'b0; s_if.rvalid = 1'b0;
            end else begin
                if (cap_aw) have_aw = 1'b1;
                if (cap_w)  have_w  = 1'b1;
                if (cap_b)  s_if.bvalid = 1'b0;
                if (have_aw && have_w && !s_if.bvalid && wq.size() > 0) begin
                    s_if.bvalid = 1'b1;
                    s_if.bresp  = wq[0].resp;
                    void'(wq.pop_front());
                    have_aw = 1'b0; have_w = 1'b0;
                end
                if (cap_r) s_if.rvalid = 1'b0;
                if (cap_ar && rq.size() > 0) begin
                    s_if.rvalid = 1'b1;
                    s_if.rdata  = rq[0].data;
                    s_if.rresp  = rq[0].resp;
                end
            end
        end
    end

    task automatic do_write(input int mid, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input int pre, input int bhold, input bit chk_lat);
        int o = 1 - mid;
        int n;
        bit aw_p, w_p, aw_hs, w_hs, granted, got;
        repeat (pre) @(posedge iCLK);
        @(posedge iCLK); #1;
        m_awvalid[mid] = 1'b1; m_awaddr[mid] = addr;
        m_wvalid[mid]  = 1'b1; m_wdata[mid]  = data; m_wstrb[mid] = strb;
        aw_p = 1'b1; w_p = 1'b1; granted = 1'b0; n = 0;
        while ((aw_p || w_p) && n < 100) begin
            @(negedge iCLK);
            if (chk_lat && n < 2) begin
                n_cmp++;
                if (s_if.awvalid !== (n == 1)) report_fail("arb_latency_s_awvalid", s_if.awvalid, (n == 1));
            end
            if (granted) begin
                n_cmp++;
                if (m_awready[o] !== 1'b0) report_fail("other_awready_while_granted", m_awready[o], 0);
                n_cmp++;
                if (m_wready[o] !== 1'b0) report_fail("other_wready_while_granted", m_wready[o], 0);
            end
            aw_hs = aw_p && m_awready[mid];
            w_hs  = w_p && m_wready[mid];
            @(posedge iCLK); #1;
            if (aw_hs) begin aw_p = 1'b0; m_awvalid[mid] = 1'b0; granted = 1'b1; end
            if (w_hs)  begin w_p  = 1'b0; m_wvalid[mid]  = 1'b0; granted = 1'b1; end
            n++;
        end
        n_cmp++;
        if ((aw_p || w_p) !== 1'b0) report_fail("write_addr_data_timeout", aw_p || w_p, 0);
        got = 1'b0; n = 0;
        while (!got && n < 100) begin
            @(negedge iCLK);
            if (m_bvalid[mid]) got = 1'b1;
            else begin @(posedge iCLK); #1; n++; end
        end
        n_cmp++;
        if (got !== 1'b1) report_fail("bvalid_timeout", got, 1);
        if (got) begin
            for (int i = 0; i < bhold; i++) begin
                n_cmp++;
                if (m_bvalid[mid] !== 1'b1) report_fail("bvalid_held", m_bvalid[mid], 1);
                n_cmp++;
                if (m_awready[o] !== 1'b0) report_fail("other_awready_during_hold", m_awready[o], 0);
                n_cmp++;
                if (m_bvalid[o] !== 1'b0) report_fail("other_bvalid_during_hold", m_bvalid[o], 0);
                @(posedge iCLK);
                @(negedge iCLK);
            end
            @(posedge iCLK); #1;
            m_bready[mid] = 1'b1;
            @(negedge iCLK);
            n_cmp++;
            if (m_bvalid[mid] !== 1'b1) report_fail("bvalid_at_accept", m_bvalid[mid], 1);
            n_cmp++;
            if (m_bvalid[o] !== 1'b0) report_fail("other_bvalid", m_bvalid[o], 0);
            n_cmp++;
            if (m_bresp[mid] !== exp_resp) report_fail("bresp", m_bresp[mid], exp_resp);
            @(posedge iCLK); #1;
            m_bready[mid] = 1'b0;
            $display("write m%0d addr=%08h data=%08h strb=%h bresp=%0d t=%0t", mid, addr, data, strb, m_bresp[mid], $time);
        end
    endtask

    task automatic do_read(input int mid, input logic [31:0] addr, input int pre);
        int o = 1 - mid;
        int n;
        bit p, hs, got;
        repeat (pre) @(posedge iCLK);
        @(posedge iCLK); #1;
        m_arvalid[mid] = 1'b1; m_araddr[mid] = addr;
        p = 1'b1; n = 0;
        while (p && n < 100) begin
            @(negedge iCLK);
            hs = m_arready[mid];
            @(posedge iCLK); #1;
            if (hs) begin p = 1'b0; m_arvalid[mid] = 1'b0; m_rready[mid] = 1'b1; end
            n++;
        end
        n_cmp++;
        if (p !== 1'b0) report_fail("read_addr_timeout", p, 0);
        got = 1'b0; n = 0;
        while (!got && n < 100) begin
            @(negedge iCLK);
            if (m_rvalid[mid]) begin
                got = 1'b1;
                n_cmp++;
                if (m_rvalid[o] !== 1'b0) report_fail("other_rvalid", m_rvalid[o], 0);
                n_cmp++;
                if ((rq.size() > 0) !== 1'b1) report_fail("rq_has_entry_at_r", rq.size(), 1);
                if (rq.size() > 0) begin
                    n_cmp++;
                    if (m_rdata[mid] !== rq[0].data) report_fail("rdata", m_rdata[mid], rq[0].data);
                    n_cmp++;
                    if (m_rresp[mid] !== rq[0].resp) report_fail("rresp", m_rresp[mid], rq[0].resp);
                end
            end else begin
                @(posedge iCLK); #1; n++;
            end
        end
        n_cmp++;
        if (got !== 1'b1) report_fail("rvalid_timeout", got, 1);
        if (got) begin
            @(posedge iCLK); #1;
            m_rready[mid] = 1'b0;
            if (rq.size() > 0) void'(rq.pop_front());
            $display("read  m%0d addr=%08h rdata=%08h rresp=%0d t=%0t", mid, addr, m_rdata[mid], m_rresp[mid], $time);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_araddr = '0;
        s_if.awready = 1'b1; s_if.wready = 1'b1; s_if.arready = 1'b1;

        #1;
        n_cmp++;
        if ({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready} !== 5'b0)
            report_fail("reset_s_valids", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready}, 0);
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== 10'b0)
            report_fail("reset_m_readies", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);
        repeat (3) @(posedge iCLK);
        #3 iRST = 1'b0;
        @(negedge iCLK);
        n_cmp++;
        if ({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready} !== 5'b0)
            report_fail("idle_s_valids", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready}, 0);
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== 10'b0)
            report_fail("idle_m_readies", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);

        for (int k = 0; k < 2; k++) begin
            wq.push_back('{addr: 32'h100 + k, data: 32'hA0A0_0000 + k, strb: 4'hF, resp: 2'b00});
            wq.push_back('{addr: 32'h200 + k, data: 32'hB1B1_0000 + k, strb: 4'h5, resp: 2'b01});
            fork
                do_write(0, 32'h100 + k, 32'hA0A0_0000 + k, 4'hF, 2'b00, 0, 0, 1'b0);
                do_write(1, 32'h200 + k, 32'hB1B1_0000 + k, 4'h5, 2'b01, 0, 0, 1'b0);
            join
        end

        wq.push_back('{addr: 32'h10, data: 32'hDEADBEEF, strb: 4'hF, resp: 2'b00});
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 1'b1);

        wq.push_back('{addr: 32'h30, data: 32'hCAFE_0003, strb: 4'h3, resp: 2'b10});
        rq.push_back('{addr: 32'h20, data: 32'h12345678, strb: 4'h0, resp: 2'b00});
        fork
            do_write(0, 32'h30, 32'hCAFE_0003, 4'h3, 2'b10, 0, 0, 1'b0);
            do_read(1, 32'h20, 0);
        join

        s_if.awready = 1'b0;
        wq.push_back('{addr: 32'h40, data: 32'h4444_0004, strb: 4'hC, resp: 2'b00});
        fork
            do_write(0, 32'h40, 32'h4444_0004, 4'hC, 2'b00, 0, 0, 1'b0);
            begin
                n = 0;
                while (!have_w && n < 50) begin @(posedge iCLK); #2; n++; end
                n_cmp++;
                if (have_w !== 1'b1) report_fail("w_first_timeout", have_w, 1);
                repeat (3) begin
                    @(negedge iCLK);
                    n_cmp++;
                    if (s_if.wvalid !== 1'b0) report_fail("s_wvalid_after_w_hs", s_if.wvalid, 0);
                    n_cmp++;
                    if (s_if.awvalid !== 1'b1) report_fail("s_awvalid_pending", s_if.awvalid, 1);
                    n_cmp++;
                    if (m_bvalid[0] !== 1'b0) report_fail("m0_bvalid_before_aw", m_bvalid[0], 0);
                end
                @(posedge iCLK); #1;
                s_if.awready = 1'b1;
            end
        join

        wq.push_back('{addr: 32'h50, data: 32'h5555_0005, strb: 4'hF, resp: 2'b00});
        wq.push_back('{addr: 32'h54, data: 32'h5454_0054, strb: 4'h1, resp: 2'b11});
        fork
            do_write(0, 32'h50, 32'h5555_0005, 4'hF, 2'b00, 0, 5, 1'b0);
            do_write(1, 32'h54, 32'h5454_0054, 4'h1, 2'b11, 1, 0, 1'b0);
        join

        rq.push_back('{addr: 32'h90, data: 32'h9090_9090, strb: 4'h0, resp: 2'b00});
        rq.push_back('{addr: 32'h94, data: 32'h9494_9494, strb: 4'h0, resp: 2'b10});
        fork
            do_read(0, 32'h90, 0);
            do_read(1, 32'h94, 0);
        join

        s_if.awready = 1'b0; s_if.wready = 1'b0;
        rq.push_back('{addr: 32'h70, data: 32'h7777_7777, strb: 4'h0, resp: 2'b00});
        @(posedge iCLK); #1;
        m_awvalid[0] = 1'b1; m_awaddr[0] = 32'h60; m_wvalid[0] = 1'b1; m_wdata[0] = 32'h6666_6666;
        m_arvalid[1] = 1'b1; m_araddr[1] = 32'h70;
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        m_arvalid[1] = 1'b0;
        @(posedge iCLK); #1;
        @(negedge iCLK);
        n_cmp++;
        if (s_if.awvalid !== 1'b1) report_fail("pre_reset_s_awvalid", s_if.awvalid, 1);
        n_cmp++;
        if (m_rvalid[1] !== 1'b1) report_fail("pre_reset_m1_rvalid", m_rvalid[1], 1);
        #1 iRST = 1'b1;
        #1;
        n_cmp++;
        if ({s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready} !== 5'b0)
            report_fail("midrst_s_valids", {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready}, 0);
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== 10'b0)
            report_fail("midrst_m_readies", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);
        m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
        wq.delete(); rq.delete();
        s_if.awready = 1'b1; s_if.wready = 1'b1;
        repeat (2) @(posedge iCLK);
        #3 iRST = 1'b0;
        wq.push_back('{addr: 32'h80, data: 32'h8888_0008, strb: 4'hF, resp: 2'b01});
        do_write(1, 32'h80, 32'h8888_0008, 4'hF, 2'b01, 0, 0, 1'b0);

        repeat (3) @(posedge iCLK);
        n_cmp++;
        if (wq.size() !== 0) report_fail("write_queue_drained", wq.size(), 0);
        n_cmp++;
        if (rq.size() !== 0) report_fail("read_queue_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
